// File: rtl/lfsr_keyspace_sequencer.sv
// Multi-channel handshaked LFSR key generator: each channel walks every LFSR state
// from the loaded seed, then issues the all-zero key, with the channel index as key MSBs.
module lfsr_keyspace_sequencer #(
  parameter int LFSR_WIDTH = 22,
  parameter int CH_BITS    = 1,
  localparam int CHANNELS  = 1 << CH_BITS,
  localparam int KEY_WIDTH = LFSR_WIDTH + CH_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            stop,
  input  logic [LFSR_WIDTH-1:0]           seed,
  input  logic [CHANNELS-1:0]             key_ready,
  output logic [CHANNELS-1:0]             key_valid,
  output logic [CHANNELS*KEY_WIDTH-1:0]   key_out,
  output logic [CHANNELS-1:0]             chan_done,
  output logic                            busy,
  output logic                            done
);

  // Handshake: a key transfers on a rising edge where key_valid and key_ready are
  // both high; key_out is held unchanged while key_valid is high and key_ready low.

  localparam logic [23:0] TAPS_FULL =
    (LFSR_WIDTH == 6)  ? 24'h000030 :
    (LFSR_WIDTH == 8)  ? 24'h0000B8 :
    (LFSR_WIDTH == 16) ? 24'h00D008 :
    (LFSR_WIDTH == 20) ? 24'h090000 :
    (LFSR_WIDTH == 22) ? 24'h300000 :
    (LFSR_WIDTH == 24) ? 24'hE10000 : 24'h000000;
  localparam logic [LFSR_WIDTH-1:0] TAPS = TAPS_FULL[LFSR_WIDTH-1:0];

  generate
    if (TAPS_FULL == 24'h0) begin : g_bad_width
      $error("lfsr_keyspace_sequencer: unsupported LFSR_WIDTH %0d", LFSR_WIDTH);
    end
    if (CH_BITS < 0 || CH_BITS > 3) begin : g_bad_ch
      $error("lfsr_keyspace_sequencer: unsupported CH_BITS %0d", CH_BITS);
    end
  endgenerate

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} g_state_t;
  typedef enum logic [1:0] {CH_ACTIVE, CH_ZERO, CH_FIN} ch_state_t;

  g_state_t              g_state, g_state_nxt;
  ch_state_t             ch_state     [CHANNELS];
  ch_state_t             ch_state_nxt [CHANNELS];
  logic [LFSR_WIDTH-1:0] lfsr         [CHANNELS];
  logic [LFSR_WIDTH-1:0] lfsr_nxt     [CHANNELS];
  logic [LFSR_WIDTH-1:0] seed_q, seed_q_nxt;
  logic [LFSR_WIDTH-1:0] seed_eff;
  logic [CHANNELS-1:0]   chan_done_q, chan_done_nxt;
  logic                  run;
  logic                  launch;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return {s[LFSR_WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign run      = (g_state == G_RUN);
  assign launch   = start && (g_state != G_RUN);
  // An all-zero seed would lock the LFSR; it is the zero key's slot anyway.
  assign seed_eff = (seed == '0) ? '1 : seed;

  always_comb begin
    g_state_nxt = g_state;
    seed_q_nxt  = seed_q;
    case (g_state)
      G_IDLE, G_DONE: begin
        if (start) begin
          g_state_nxt = G_RUN;
          seed_q_nxt  = seed_eff;
        end
      end
      G_RUN: begin
        if (stop || (&chan_done_nxt)) g_state_nxt = G_DONE;
      end
      default: g_state_nxt = G_IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ch_state_nxt[c]  = ch_state[c];
      lfsr_nxt[c]      = lfsr[c];
      chan_done_nxt[c] = chan_done_q[c];
      if (launch) begin
        ch_state_nxt[c]  = CH_ACTIVE;
        lfsr_nxt[c]      = seed_eff;
        chan_done_nxt[c] = 1'b0;
      end else if (key_valid[c] && key_ready[c]) begin
        case (ch_state[c])
          CH_ACTIVE: begin
            // Returning to the seed means every nonzero state has been issued.
            if (lfsr_step(lfsr[c]) == seed_q) begin
              lfsr_nxt[c]     = '0;
              ch_state_nxt[c] = CH_ZERO;
            end else begin
              lfsr_nxt[c] = lfsr_step(lfsr[c]);
            end
          end
          CH_ZERO: begin
            ch_state_nxt[c]  = CH_FIN;
            chan_done_nxt[c] = 1'b1;
          end
          default: ch_state_nxt[c] = CH_FIN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_state     <= G_IDLE;
      seed_q      <= '0;
      chan_done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_state[c] <= CH_FIN;
        lfsr[c]     <= '0;
      end
    end else begin
      g_state     <= g_state_nxt;
      seed_q      <= seed_q_nxt;
      chan_done_q <= chan_done_nxt;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_state[c] <= ch_state_nxt[c];
        lfsr[c]     <= lfsr_nxt[c];
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam logic [KEY_WIDTH-1:0] PREFIX = KEY_WIDTH'(c) << LFSR_WIDTH;
      assign key_valid[c] = run && (ch_state[c] != CH_FIN);
      assign key_out[c*KEY_WIDTH +: KEY_WIDTH] =
        (g_state == G_IDLE) ? '0 : (PREFIX | KEY_WIDTH'(lfsr[c]));
    end
  endgenerate

  assign chan_done = chan_done_q;
  assign busy      = run;
  assign done      = (g_state == G_DONE);

endmodule

// File: tb/tb_lfsr_keyspace_sequencer.sv
// Bench for lfsr_keyspace_sequencer (6-bit LFSR, two channels): per-channel expected
// key queues built from the sequence definition, checked every cycle.
module tb_lfsr_keyspace_sequencer;

  localparam int W   = 6;
  localparam int CB  = 1;
  localparam int CHN = 2;
  localparam int KW  = W + CB;
  localparam logic [W-1:0] TAPS = 6'h30;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [W-1:0] seed = '0;
  logic [CHN-1:0] key_ready = '0;
  logic [CHN-1:0] key_valid;
  logic [CHN*KW-1:0] key_out;
  logic [CHN-1:0] chan_done;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  lfsr_keyspace_sequencer #(.LFSR_WIDTH(W), .CH_BITS(CB)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .seed(seed),
    .key_ready(key_ready), .key_valid(key_valid), .key_out(key_out),
    .chan_done(chan_done), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 done
  logic [KW-1:0] exp_q [CHN][$];
  int m_state = 0;
  logic [CHN-1:0] m_chan_done = '0;
  int hs_cnt [CHN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    logic fb;
    fb = ($countones(s & TAPS) % 2) == 1;
    return W'({s, fb});
  endfunction

  // Expected stream per channel: all nonzero states from the seed, then zero.
  task automatic build_model(input logic [W-1:0] s_in);
    logic [W-1:0] s0, s;
    for (int c = 0; c < CHN; c++) begin
      exp_q[c].delete();
      s0 = (s_in == '0) ? '1 : s_in;
      s = s0;
      for (int i = 0; i < (1 << W); i++) begin
        exp_q[c].push_back(KW'(c << W) | KW'(s));
        s = lfsr_next(s);
        if (s == s0) break;
      end
      exp_q[c].push_back(KW'(c << W));
      hs_cnt[c] = 0;
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_state == 2));
    check("chan_done", 32'(chan_done), 32'(m_chan_done));
    for (int c = 0; c < CHN; c++) begin
      logic v;
      v = (m_state == 1) && (exp_q[c].size() > 0);
      check($sformatf("key_valid[%0d]", c), 32'(key_valid[c]), 32'(v));
      if (v) check($sformatf("key_out[%0d]", c), 32'(key_out[c*KW +: KW]), 32'(exp_q[c][0]));
      if (m_state == 0) check($sformatf("idle_key_out[%0d]", c), 32'(key_out[c*KW +: KW]), 32'h0);
    end
    if (reset) begin
      m_state = 0;
      m_chan_done = '0;
      for (int c = 0; c < CHN; c++) exp_q[c].delete();
    end else if (m_state == 1) begin
      for (int c = 0; c < CHN; c++) begin
        if (exp_q[c].size() > 0 && key_ready[c]) begin
          void'(exp_q[c].pop_front());
          hs_cnt[c]++;
          if (exp_q[c].size() == 0) m_chan_done[c] = 1'b1;
        end
      end
      if (stop || (&m_chan_done)) m_state = 2;
    end else if (start) begin
      build_model(seed);
      m_chan_done = '0;
      m_state = 1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] s);
    seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_within_budget", 32'(done), 32'h1);
  endtask

  initial begin
    int k;
    int distinct;
    logic [127:0] seen;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Full run, ready held high, seed 3F
    key_ready = 2'b11;
    pulse_start(6'h3F);
    check("pin_q0_size", 32'(exp_q[0].size()), 32'd64);
    check("pin_q0_first", 32'(exp_q[0][0]), 32'h3F);
    check("pin_q0_idx6", 32'(exp_q[0][6]), 32'h01);
    check("pin_q0_last", 32'(exp_q[0][63]), 32'h00);
    check("pin_q1_first", 32'(exp_q[1][0]), 32'h7F);
    check("pin_q1_last", 32'(exp_q[1][63]), 32'h40);
    seen = '0;
    distinct = 0;
    for (int i = 0; i < exp_q[0].size(); i++) begin
      if (!seen[exp_q[0][i]]) distinct++;
      seen[exp_q[0][i]] = 1'b1;
    end
    check("pin_q0_distinct", 32'(distinct), 32'd64);
    check("first_key_ch0", 32'(key_out[0 +: KW]), 32'h3F);
    check("first_key_ch1", 32'(key_out[KW +: KW]), 32'h7F);
    tick();
    check("second_key_ch0", 32'(key_out[0 +: KW]), 32'h3E);
    check("second_key_ch1", 32'(key_out[KW +: KW]), 32'h7E);
    repeat (8) tick();
    pulse_start(6'h05);
    wait_done(200);
    check("hs_cnt_ch0", 32'(hs_cnt[0]), 32'd64);
    check("hs_cnt_ch1", 32'(hs_cnt[1]), 32'd64);
    tick();

    // Backpressure on channel 1 only
    pulse_start(6'h15);
    k = 0;
    while (!chan_done[0] && k < 200) begin
      key_ready = {1'($urandom_range(0, 1)), 1'b1};
      tick();
      k++;
    end
    check("ch0_done_cycles", 32'(k), 32'd64);
    check("busy_after_ch0", 32'(busy), 32'h1);
    k = 0;
    while (!done && k < 1000) begin
      key_ready = {1'($urandom_range(0, 1)), 1'b1};
      tick();
      k++;
    end
    check("bp_done", 32'(done), 32'h1);
    key_ready = 2'b11;
    tick();

    // Stop with a channel-0 handshake in the same cycle, then restart
    pulse_start(6'h2A);
    repeat (10) tick();
    key_ready = 2'b01;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", 32'(key_valid), 32'h0);
    check("stop_done", 32'(done), 32'h1);
    repeat (2) tick();
    key_ready = 2'b11;
    pulse_start(6'h01);
    check("restart_ch0", 32'(key_out[0 +: KW]), 32'h01);
    check("restart_ch1", 32'(key_out[KW +: KW]), 32'h41);

    // start and stop together in RUN: stop wins
    repeat (4) tick();
    seed = 6'h10;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_done", 32'(done), 32'h1);
    check("startstop_busy", 32'(busy), 32'h0);

    // Reset in the middle of a run
    pulse_start(6'h01);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_chan_done", 32'(chan_done), 32'h0);

    // Zero seed is replaced by all ones
    pulse_start(6'h00);
    check("zero_seed_ch0", 32'(key_out[0 +: KW]), 32'h3F);
    wait_done(200);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_keyspace_sequencer.md
# lfsr_keyspace_sequencer

Multi-channel, handshaked LFSR key generator for the RC4 brute-force search. Splits the key space across 2^CH_BITS decryption cores by fixing the key's top CH_BITS bits to the channel index; each channel steps its own maximal-length LFSR for the low bits. Unlike the plain LFSR counter, it covers the full space including the all-zero LFSR state, signals per-channel and global completion, and supports early abort when a key is found. Sits between the search controller and the array of decryption cores.

## Interface
- LFSR_WIDTH, 22: LFSR bits per channel; legal values 6, 8, 16, 20, 22, 24 (any other value is a synthesis error)
- CH_BITS, 1: channel index bits, 0..3; CHANNELS = 2^CH_BITS
- KEY_WIDTH (derived): LFSR_WIDTH + CH_BITS
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; launches a search from IDLE or DONE
- stop  in  1  pulse; abort (key found), honoured only in RUN
- seed  in  LFSR_WIDTH  start state, sampled on accepted start; zero is replaced by all ones
- key_ready  in  CHANNELS  per-channel consumer ready
- key_valid  out  CHANNELS  per-channel key available
- key_out  out  CHANNELS*KEY_WIDTH  channel c occupies bits [c*KEY_WIDTH +: KEY_WIDTH]; = {c[CH_BITS-1:0], lfsr_c}
- chan_done  out  CHANNELS  channel c has issued all 2^LFSR_WIDTH keys
- busy  out  1  global state RUN
- done  out  1  global state DONE (exhausted or stopped)

## Operation
- Tap masks (feedback = XOR-reduce of state & mask, shifted into bit 0, state shifts left): 6: 6'h30; 8: 8'hB8; 16: 16'hD008; 20: 20'h90000; 22: 22'h300000; 24: 24'hE10000.
- Global FSM: IDLE -> RUN on start; RUN -> DONE when all chan_done high or on stop; DONE -> RUN on start (restart, all channels reloaded); start ignored in RUN; stop ignored outside RUN.
- Per-channel FSM: ACTIVE -> ZERO -> FIN.
  - On start: every channel loads lfsr = seed (or all ones if seed == 0), state ACTIVE, chan_done cleared.
  - ACTIVE: key_valid high; on key_valid & key_ready, lfsr <= next(lfsr); if next(lfsr) == loaded seed, go to ZERO instead and set lfsr to 0.
  - ZERO: key_valid high, key_out low bits all zero; on handshake go to FIN, chan_done <= 1.
  - FIN: key_valid low, holds.
- Each channel issues exactly 2^LFSR_WIDTH distinct keys: 2^LFSR_WIDTH-1 LFSR states in sequence order, then the zero key.
- key_valid forced low in IDLE and DONE regardless of channel state.
- key_out only changes on that channel's handshake or on start; stable while valid & !ready.

## Timing
- Reset: global IDLE, all key_valid 0, key_out 0, chan_done 0, busy 0, done 0.
- start at cycle t: busy and key_valid high from t+1 with key_out = {c, seed}.
- Throughput: one key per channel per cycle with ready held high; handshake at t -> new key_out at t+1.
- Channels independent; stalling one never affects others.
- Last zero-key handshake on final unfinished channel at t: chan_done, done high and busy low at t+1.
- stop at t coinciding with handshakes: those handshakes count (consumer has the key); all key_valid low, done high at t+1; chan_done unchanged.
- start and stop same cycle in RUN: stop wins; start ignored.
- reset mid-search: IDLE next cycle, all outputs to reset values, seed discarded.

## Test plan
- LFSR_WIDTH=6, CH_BITS=1, seed 6'h3F, ready held 1: cycle after start key_out ch0 = 7'h3F, ch1 = 7'h7F; next cycle 7'h3E / 7'h7E; each channel emits 64 distinct keys, last ch0 = 7'h00, ch1 = 7'h40; done one cycle after 64th handshake.
- Seed 0 with LFSR_WIDTH=8, CH_BITS=0: first key 8'hFF; 256 keys, all values 0..255 seen exactly once.
- Backpressure: ch1 ready toggled randomly, ch0 ready 1: ch0 finishes after 64 cycles with chan_done[0]=1 while busy stays 1; key_out[1] stable during stalls; done only after ch1 completes.
- stop mid-run with ch0 handshake same cycle: that key counted, all key_valid 0 and done 1 next cycle; subsequent start with seed 6'h01 restarts with key_out ch0 = 7'h01.
- reset asserted during RUN: next cycle all key_valid 0, busy 0, done 0, chan_done 0; start during RUN (no stop) has no effect on sequence.
- LFSR_WIDTH=20, CH_BITS=0 period check: 2^20 handshakes, no repeated key, final key 20'h0.
